// File: rtl/tsp_arbiter.sv
// Two-requester round-robin arbiter feeding a shared non-stalling 3-stage pipeline,
// with credit-gated issue and per-requester response FIFOs. Optional: TSP_ARB_STATS_EN.

module three_stage_pipeline #(
  parameter int DWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DWIDTH-1:0] i_op1,
  input  logic [DWIDTH-1:0] i_op2,
  output logic [DWIDTH-1:0] o_result
);
  logic [DWIDTH-1:0] r_a, r_sum, r_diff, r_res;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a    <= '0;
      r_sum  <= '0;
      r_diff <= '0;
      r_res  <= '0;
    end else begin
      r_a    <= i_op1;
      r_sum  <= i_op1 + i_op2;
      r_diff <= r_sum - r_a;
      r_res  <= r_diff;
    end
  end

  assign o_result = r_res;
endmodule

module tsp_arb_buf #(
  parameter int DWIDTH = 32,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [DWIDTH-1:0]        i_data,
  input  logic                     i_pop,
  output logic [$clog2(DEPTH):0]   o_occ,
  output logic [DWIDTH-1:0]        o_data
);
  localparam int AW = $clog2(DEPTH);

  logic [DWIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr, r_rd;
  logic [AW:0]       r_occ;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_occ <= '0;
    end else begin
      if (i_push) r_wr <= r_wr + 1'b1;
      if (i_pop)  r_rd <= r_rd + 1'b1;
      r_occ <= r_occ + (AW+1)'(i_push) - (AW+1)'(i_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr] <= i_data;
  end

  // Credit gating must make a push into a full buffer unreachable.
  always_ff @(posedge clk) begin
    if (!rst && i_push && !i_pop) assert (r_occ < (AW+1)'(DEPTH));
  end

  assign o_occ  = r_occ;
  assign o_data = (r_occ != '0) ? r_mem[r_rd] : '0;
endmodule

module tsp_arbiter #(
  parameter int DWIDTH    = 32,
  parameter int BUF_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid_i,
  output logic              req0_ready_o,
  input  logic [DWIDTH-1:0] req0_op1_i,
  input  logic [DWIDTH-1:0] req0_op2_i,
  input  logic              req1_valid_i,
  output logic              req1_ready_o,
  input  logic [DWIDTH-1:0] req1_op1_i,
  input  logic [DWIDTH-1:0] req1_op2_i,
  output logic              rsp0_valid_o,
  input  logic              rsp0_ready_i,
  output logic [DWIDTH-1:0] rsp0_data_o,
  output logic              rsp1_valid_o,
  input  logic              rsp1_ready_i,
  output logic [DWIDTH-1:0] rsp1_data_o,
  output logic              busy_o
`ifdef TSP_ARB_STATS_EN
  ,
  output logic [15:0]       gnt0_cnt_o,
  output logic [15:0]       gnt1_cnt_o
`endif
);
  localparam int CW = $clog2(BUF_DEPTH) + 1;

  logic [1:0]             w_req_vld, w_elig, w_gnt, w_push, w_pop, w_rsp_rdy, w_rsp_vld;
  logic [1:0][DWIDTH-1:0] w_op1, w_op2, w_rsp_data;
  logic [1:0][CW-1:0]     w_occ, w_occ_nxt, r_infl;
  logic [DWIDTH-1:0]      w_pipe_op1, w_pipe_op2, w_pipe_res;
  logic [2:0]             r_tag_vld, r_tag_own;
  logic                   r_last, r_busy;

  assign w_req_vld = {req1_valid_i, req0_valid_i};
  assign w_op1     = {req1_op1_i, req0_op1_i};
  assign w_op2     = {req1_op2_i, req0_op2_i};
  assign w_rsp_rdy = {rsp1_ready_i, rsp0_ready_i};

  for (genvar n = 0; n < 2; n++) begin : g_req
    logic [CW:0] w_used;
    // Credit comes from registered counts only, so a same-cycle pop frees space next cycle.
    assign w_used       = {1'b0, r_infl[n]} + {1'b0, w_occ[n]};
    assign w_elig[n]    = !rst && w_req_vld[n] && (w_used < (CW+1)'(BUF_DEPTH));
    assign w_push[n]    = r_tag_vld[2] && (r_tag_own[2] == 1'(n));
    assign w_rsp_vld[n] = (w_occ[n] != '0);
    assign w_pop[n]     = w_rsp_vld[n] && w_rsp_rdy[n];
    assign w_occ_nxt[n] = w_occ[n] + CW'(w_push[n]) - CW'(w_pop[n]);

    tsp_arb_buf #(.DWIDTH(DWIDTH), .DEPTH(BUF_DEPTH)) u_buf (
      .clk    (clk),
      .rst    (rst),
      .i_push (w_push[n]),
      .i_data (w_pipe_res),
      .i_pop  (w_pop[n]),
      .o_occ  (w_occ[n]),
      .o_data (w_rsp_data[n])
    );

    always_ff @(posedge clk) begin
      if (rst) r_infl[n] <= '0;
      else     r_infl[n] <= r_infl[n] + CW'(w_gnt[n]) - CW'(w_push[n]);
    end
  end

  assign w_gnt[0] = w_elig[0] && (!w_elig[1] ||  r_last);
  assign w_gnt[1] = w_elig[1] && (!w_elig[0] || !r_last);

  always_comb begin
    w_pipe_op1 = '0;
    w_pipe_op2 = '0;
    if (w_gnt[0]) begin
      w_pipe_op1 = w_op1[0];
      w_pipe_op2 = w_op2[0];
    end else if (w_gnt[1]) begin
      w_pipe_op1 = w_op1[1];
      w_pipe_op2 = w_op2[1];
    end
  end

  three_stage_pipeline #(.DWIDTH(DWIDTH)) u_pipe (
    .clk      (clk),
    .rst      (rst),
    .i_op1    (w_pipe_op1),
    .i_op2    (w_pipe_op2),
    .o_result (w_pipe_res)
  );

  // Tag tail lines up with the pipeline output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tag_vld <= '0;
      r_tag_own <= '0;
      r_last    <= 1'b1;
      r_busy    <= 1'b0;
    end else begin
      r_tag_vld <= {r_tag_vld[1:0], |w_gnt};
      r_tag_own <= {r_tag_own[1:0], w_gnt[1]};
      if (|w_gnt) r_last <= w_gnt[1];
      r_busy <= (|r_tag_vld[1:0]) || (|w_gnt) || (w_occ_nxt[0] != '0) || (w_occ_nxt[1] != '0);
    end
  end

  assign req0_ready_o = w_gnt[0];
  assign req1_ready_o = w_gnt[1];
  assign rsp0_valid_o = w_rsp_vld[0];
  assign rsp1_valid_o = w_rsp_vld[1];
  assign rsp0_data_o  = w_rsp_data[0];
  assign rsp1_data_o  = w_rsp_data[1];
  assign busy_o       = r_busy;

`ifdef TSP_ARB_STATS_EN
  logic [1:0][15:0] r_gnt_cnt;

  always_ff @(posedge clk) begin
    if (rst) r_gnt_cnt <= '0;
    else begin
      for (int n = 0; n < 2; n++)
        if (w_gnt[n] && r_gnt_cnt[n] != 16'hFFFF) r_gnt_cnt[n] <= r_gnt_cnt[n] + 16'd1;
    end
  end

  assign gnt0_cnt_o = r_gnt_cnt[0];
  assign gnt1_cnt_o = r_gnt_cnt[1];
`endif
endmodule

// File: tb/tb_tsp_arbiter.sv
// Directed self-checking bench for tsp_arbiter (DWIDTH=32, BUF_DEPTH=4).
module tb_tsp_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_op1, req0_op2, req1_op1, req1_op2;
  logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [31:0] rsp0_data, rsp1_data;
  logic        busy;
`ifdef TSP_ARB_STATS_EN
  logic [15:0] gnt0_cnt, gnt1_cnt;
`endif
  int checks = 0;
  int errors = 0;

  tsp_arbiter #(.DWIDTH(32), .BUF_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .req0_valid_i(req0_valid), .req0_ready_o(req0_ready), .req0_op1_i(req0_op1), .req0_op2_i(req0_op2),
    .req1_valid_i(req1_valid), .req1_ready_o(req1_ready), .req1_op1_i(req1_op1), .req1_op2_i(req1_op2),
    .rsp0_valid_o(rsp0_valid), .rsp0_ready_i(rsp0_ready), .rsp0_data_o(rsp0_data),
    .rsp1_valid_o(rsp1_valid), .rsp1_ready_i(rsp1_ready), .rsp1_data_o(rsp1_data),
    .busy_o(busy)
`ifdef TSP_ARB_STATS_EN
    , .gnt0_cnt_o(gnt0_cnt), .gnt1_cnt_o(gnt1_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req0_valid = 0; req1_valid = 0; rsp0_ready = 0; rsp1_ready = 0;
    req0_op1 = 0; req0_op2 = 0; req1_op1 = 0; req1_op2 = 0;
  endtask

  task automatic do_reset();
    rst = 1; idle_inputs();
    step(); step();
    rst = 0;
  endtask

  task automatic test_reset();
    rst = 1; idle_inputs();
    step(); step();
    checks++; if (req0_ready !== 1'b0) begin errors++; $display("FAIL reset_req0_ready got %b exp 0", req0_ready); end
    checks++; if (req1_ready !== 1'b0) begin errors++; $display("FAIL reset_req1_ready got %b exp 0", req1_ready); end
    checks++; if (rsp0_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp0_valid got %b exp 0", rsp0_valid); end
    checks++; if (rsp1_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp1_valid got %b exp 0", rsp1_valid); end
    checks++; if (rsp0_data !== 32'h0) begin errors++; $display("FAIL reset_rsp0_data got %h exp 0", rsp0_data); end
    checks++; if (rsp1_data !== 32'h0) begin errors++; $display("FAIL reset_rsp1_data got %h exp 0", rsp1_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    rst = 0;
  endtask

  task automatic test_single();
    req0_valid = 1; req0_op1 = 5; req0_op2 = 7; rsp0_ready = 1;
    #1;
    checks++; if ({req1_ready, req0_ready} !== 2'b01) begin errors++; $display("FAIL single_grant got %b exp 01", {req1_ready, req0_ready}); end
    step();
    req0_valid = 0; req0_op1 = 0; req0_op2 = 0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_hi got %b exp 1", busy); end
    step(); step();
    checks++; if (rsp0_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid got %b exp 0", rsp0_valid); end
    step();
    checks++; if (rsp0_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b exp 1", rsp0_valid); end
    checks++; if (rsp0_data !== 32'd7) begin errors++; $display("FAIL single_data got %h exp 7", rsp0_data); end
    step();
    checks++; if (rsp0_valid !== 1'b0) begin errors++; $display("FAIL single_popped got %b exp 0", rsp0_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_lo got %b exp 0", busy); end
  endtask

  task automatic test_contention();
    int s0 = 0, s1 = 0, r0 = 0, r1 = 0;
    do_reset();
    rsp0_ready = 1; rsp1_ready = 1;
    for (int c = 0; c < 8; c++) begin
      req0_valid = 1; req1_valid = 1;
      req0_op1 = 32'(c * 3); req1_op1 = 32'(c * 5 + 1);
      req0_op2 = 32'h100 + 32'(s0); req1_op2 = 32'h200 + 32'(s1);
      #1;
      checks++;
      if ({req1_ready, req0_ready} !== ((c % 2 == 0) ? 2'b01 : 2'b10)) begin
        errors++; $display("FAIL contention_grant cycle %0d got %b exp %b", c, {req1_ready, req0_ready}, (c % 2 == 0) ? 2'b01 : 2'b10);
      end
      if (req0_ready) s0++;
      if (req1_ready) s1++;
      if (rsp0_valid) begin
        checks++; if (rsp0_data !== 32'h100 + 32'(r0)) begin errors++; $display("FAIL contention_rsp0 got %h exp %h", rsp0_data, 32'h100 + 32'(r0)); end
        r0++;
      end
      if (rsp1_valid) begin
        checks++; if (rsp1_data !== 32'h200 + 32'(r1)) begin errors++; $display("FAIL contention_rsp1 got %h exp %h", rsp1_data, 32'h200 + 32'(r1)); end
        r1++;
      end
      step();
    end
    req0_valid = 0; req1_valid = 0;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (rsp0_valid) begin
        checks++; if (rsp0_data !== 32'h100 + 32'(r0)) begin errors++; $display("FAIL contention_rsp0 got %h exp %h", rsp0_data, 32'h100 + 32'(r0)); end
        r0++;
      end
      if (rsp1_valid) begin
        checks++; if (rsp1_data !== 32'h200 + 32'(r1)) begin errors++; $display("FAIL contention_rsp1 got %h exp %h", rsp1_data, 32'h200 + 32'(r1)); end
        r1++;
      end
      step();
    end
    checks++; if (r0 != 4 || r1 != 4) begin errors++; $display("FAIL contention_count got %0d/%0d exp 4/4", r0, r1); end
  endtask

  task automatic test_backpressure();
    int n = 0;
    do_reset();
    for (int c = 0; c < 12; c++) begin
      req1_valid = 1; req1_op1 = 32'(c); req1_op2 = 32'h300 + 32'(n);
      #1;
      if (req1_ready) n++;
      step();
    end
    checks++; if (n != 4) begin errors++; $display("FAIL bp_grants got %0d exp 4", n); end
    checks++; if (req1_ready !== 1'b0) begin errors++; $display("FAIL bp_blocked got %b exp 0", req1_ready); end
    checks++; if (rsp1_valid !== 1'b1 || rsp1_data !== 32'h300) begin errors++; $display("FAIL bp_head got %b/%h exp 1/300", rsp1_valid, rsp1_data); end
    rsp1_ready = 1;
    #1;
    checks++; if (req1_ready !== 1'b0) begin errors++; $display("FAIL bp_pop_same_cycle got %b exp 0", req1_ready); end
    step();
    rsp1_ready = 0;
    n = 0;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (req1_ready) n++;
      step();
    end
    checks++; if (n != 1) begin errors++; $display("FAIL bp_extra_grant got %0d exp 1", n); end
    req1_valid = 0; rsp1_ready = 1;
    n = 0;
    for (int c = 0; c < 8; c++) begin
      if (rsp1_valid) begin
        checks++; if (rsp1_data !== 32'h301 + 32'(n)) begin errors++; $display("FAIL bp_drain got %h exp %h", rsp1_data, 32'h301 + 32'(n)); end
        n++;
      end
      step();
    end
    checks++; if (n != 4 || busy !== 1'b0) begin errors++; $display("FAIL bp_drained got %0d/%b exp 4/0", n, busy); end
  endtask

  task automatic test_wrap();
    int lat = -1;
    req1_valid = 1; req1_op1 = 32'hFFFF_FFFF; req1_op2 = 32'h0000_0002; rsp1_ready = 1;
    #1;
    checks++; if (req1_ready !== 1'b1) begin errors++; $display("FAIL wrap_grant got %b exp 1", req1_ready); end
    step();
    req1_valid = 0;
    for (int i = 1; i <= 8; i++) begin
      if (rsp1_valid && lat < 0) begin
        lat = i - 1;
        checks++; if (rsp1_data !== 32'h0000_0002) begin errors++; $display("FAIL wrap_data got %h exp 00000002", rsp1_data); end
      end
      step();
    end
    checks++; if (lat != 3) begin errors++; $display("FAIL wrap_latency got %0d exp 3", lat); end
  endtask

  task automatic test_reset_mid();
    int bad = 0;
    req0_valid = 1; req0_op1 = 1; req0_op2 = 32'h55; rsp0_ready = 1;
    #1;
    checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL rmid_grant got %b exp 1", req0_ready); end
    step();
    req0_valid = 0; rst = 1;
    step();
    rst = 0;
    checks++; if (busy !== 1'b0 || rsp0_valid !== 1'b0) begin errors++; $display("FAIL rmid_after_reset busy %b valid %b exp 0/0", busy, rsp0_valid); end
    for (int i = 0; i < 6; i++) begin
      step();
      if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0 || busy !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL rmid_no_writeback got %0d bad cycles exp 0", bad); end
  endtask

`ifdef TSP_ARB_STATS_EN
  task automatic test_stats();
    int n = 0, g = 0;
    do_reset();
    checks++; if (gnt0_cnt !== 16'd0 || gnt1_cnt !== 16'd0) begin errors++; $display("FAIL stats_reset got %0d/%0d exp 0/0", gnt0_cnt, gnt1_cnt); end
    rsp0_ready = 1; rsp1_ready = 1;
    while (n < 10 && g < 100) begin
      req0_valid = 1; #1;
      if (req0_ready) n++;
      step(); g++;
    end
    req0_valid = 0; n = 0; g = 0;
    while (n < 3 && g < 100) begin
      req1_valid = 1; #1;
      if (req1_ready) n++;
      step(); g++;
    end
    req1_valid = 0;
    repeat (6) step();
    checks++; if (gnt0_cnt !== 16'd10) begin errors++; $display("FAIL stats_gnt0 got %0d exp 10", gnt0_cnt); end
    checks++; if (gnt1_cnt !== 16'd3) begin errors++; $display("FAIL stats_gnt1 got %0d exp 3", gnt1_cnt); end
    do_reset();
    checks++; if (gnt0_cnt !== 16'd0 || gnt1_cnt !== 16'd0) begin errors++; $display("FAIL stats_rereset got %0d/%0d exp 0/0", gnt0_cnt, gnt1_cnt); end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_wrap();
    test_reset_mid();
`ifdef TSP_ARB_STATS_EN
    test_stats();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/tsp_arbiter.md
Name: tsp_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer for a shared three_stage_pipeline instance, which it instantiates internally.
- Accepts operand pairs over valid/ready from two clients and issues at most one pair per cycle into the pipeline.
- Tracks each issued operation's owner through the pipeline and steers the result into a per-requester response buffer.
- The pipeline has no stall capability, so issue is credit-gated to guarantee buffer space for every in-flight result.

Parameters:
- DWIDTH, 32, operand/result width; passed to the pipeline.
- BUF_DEPTH, 4, entries per response buffer; power of two, ≥2.

Ports:
- clk  input  1  clock
- rst  input  1  reset
- req0_valid_i  input  1  requester 0 has an operand pair
- req0_ready_o  output  1  requester 0 pair accepted this cycle
- req0_op1_i  input  DWIDTH  requester 0 operand 1
- req0_op2_i  input  DWIDTH  requester 0 operand 2
- req1_valid_i  input  1  requester 1 has an operand pair
- req1_ready_o  output  1  requester 1 pair accepted this cycle
- req1_op1_i  input  DWIDTH  requester 1 operand 1
- req1_op2_i  input  DWIDTH  requester 1 operand 2
- rsp0_valid_o  output  1  requester 0 response buffer non-empty
- rsp0_ready_i  input  1  requester 0 consumes its head entry
- rsp0_data_o  output  DWIDTH  requester 0 head result
- rsp1_valid_o  output  1  requester 1 response buffer non-empty
- rsp1_ready_i  input  1  requester 1 consumes its head entry
- rsp1_data_o  output  DWIDTH  requester 1 head result
- busy_o  output  1  any operation in flight or any buffer non-empty

Behaviour:
- Reset and clocking:
  - Single clock domain; reset is synchronous, active-high, and also resets the internal pipeline.
  - Reset values: req*_ready_o=0, rsp*_valid_o=0, rsp*_data_o=0, busy_o=0.
  - After reset: buffers empty, in-flight tags cleared, last_grant=1 (so requester 0 wins the first contention).
- Credit and eligibility:
  - credit_n = BUF_DEPTH − occ_n − inflight_n, computed from registered counts.
  - A pop in the same cycle does not raise credit until the next cycle.
  - Requester n is eligible when req_n_valid_i=1 and credit_n>0.
- Arbitration (combinational):
  - One eligible requester: grant it.
  - Both eligible: grant the requester ≠ last_grant.
  - None eligible: no issue; drive pipeline operands 0.
  - req_n_ready_o = grant_n; it may depend on req_n_valid_i.
  - last_grant updates only on a grant.
- Issue:
  - The granted pair drives the pipeline op1_i/op2_i in the grant cycle and is sampled at that rising edge (edge k).
- Tag pipeline:
  - Three-deep shift register of {valid, owner} advances every cycle.
  - It loads at edge k and is aligned with the pipeline result after edge k+2.
- Writeback:
  - In the cycle after edge k+2, the tag-tail valid writes the pipeline result into the owner's buffer.
  - The write lands at edge k+3.
  - Grant-to-rsp_valid latency is 3 cycles with an empty buffer.
- Arithmetic:
  - Pipeline result = (op1+op2)−op1 mod 2^DWIDTH, which equals op2.
  - Wrap-around is silent; no flags.
- Response buffers:
  - FIFO order per requester; rsp_data_o shows the head.
  - Pop occurs when rsp_valid_o && rsp_ready_i.
  - Push and pop in the same cycle: occupancy unchanged, order preserved.
  - Overflow is impossible by construction; it is an assertion target.
- Counters:
  - inflight_n increments on grant_n and decrements on writeback for n; both in the same cycle leaves it unchanged.
  - Counters are sized to hold BUF_DEPTH.
- Full/blocked requester:
  - When credit_n=0, requester n is never granted.
  - The other requester may be granted every cycle (no forced alternation when only one is eligible).
- Reset mid-operation: all in-flight results are discarded and no writeback occurs after reset.
- busy_o is registered: OR of all tag valids and (occ≠0) for both requesters.

Optional Feature:
- Macro: TSP_ARB_STATS_EN.
- When defined, adds outputs gnt0_cnt_o and gnt1_cnt_o, each 16 bits:
  - Increment on each grant to that requester.
  - Saturate at 0xFFFF.
  - Reset to 0.
- When undefined, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Single issue: after reset, req0 sends op1=5, op2=7 for one cycle, rsp0_ready=1. Required: req0_ready=1 in that cycle; rsp0_valid=1 with data=7 exactly 3 cycles later; busy_o returns to 0.
- Contention: both valid continuously with distinct op2 values, both rsp_ready=1. Required: grants alternate 0,1,0,1…; each requester receives its own results in order.
- Backpressure: rsp1_ready=0, req1 valid continuously, BUF_DEPTH=4. Required: exactly 4 grants to requester 1, then req1_ready=0; raising rsp1_ready for one cycle yields exactly one further grant.
- Wrap: op1=0xFFFFFFFF, op2=0x00000002. Required: result 0x00000002 with no error.
- Reset mid-flight: rst asserted 1 cycle after a grant. Required: no rsp_valid afterwards, occupancy 0, busy_o=0 the cycle after reset deasserts.
- Stats (TSP_ARB_STATS_EN): 10 grants to req0 and 3 to req1. Required: gnt0_cnt_o=10, gnt1_cnt_o=3; both read 0 after reset.
